// File: rtl/bitstream_pkg.sv
// bitstream_pkg: width and geometry helpers shared by the constant-bitstream blocks.
package bitstream_pkg;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit geom_ok(input int len, input int word);
      return (word > 0) && (len >= word) && (len % word == 0);
   endfunction

endpackage

// File: rtl/const_pattern_ch.sv
// const_pattern_ch: one channel's LEN-bit pattern register with a word write port and a bit read port.
module const_pattern_ch
   import bitstream_pkg::*;
#(
   parameter int LEN  = 512,
   parameter int WORD = 32
) (
   input  logic                            clk,
   input  logic                            i_we,
   input  logic [idx_w(LEN/WORD)-1:0]      i_addr,
   input  logic [WORD-1:0]                 i_data,
   input  logic [idx_w(LEN)-1:0]           i_idx,
   output logic                            o_bit
);

   logic [LEN-1:0] r_pat;

   always_ff @(posedge clk) begin
      if (i_we) r_pat[int'(i_addr)*WORD +: WORD] <= i_data;
   end

   assign o_bit = r_pat[i_idx];

endmodule

// File: rtl/const_stream_bank.sv
// const_stream_bank: N-channel cyclic constant-bitstream source with run-time loadable patterns.
module const_stream_bank
   import bitstream_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int LEN    = 512,
   parameter int WORD   = 32,
   parameter int OFFSET = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_run_en,
   input  logic                            i_sync_clr,
   input  logic [N_CH-1:0]                 i_ch_mask,
   input  logic                            i_ld_valid,
   output logic                            o_ld_ready,
   input  logic [idx_w(N_CH)-1:0]          i_ld_ch,
   input  logic [idx_w(LEN/WORD)-1:0]      i_ld_addr,
   input  logic [WORD-1:0]                 i_ld_data,
   output logic [N_CH-1:0]                 o_bits_out,
   output logic                            o_bits_valid,
   output logic                            o_wrap,
   output logic [idx_w(LEN)-1:0]           o_idx_out
);

   typedef logic [idx_w(N_CH)-1:0] ch_idx_t;
   typedef logic [idx_w(LEN)-1:0]  bit_idx_t;

   localparam bit_idx_t IDX_RST  = bit_idx_t'(OFFSET);
   localparam bit_idx_t IDX_LAST = bit_idx_t'(LEN - 1);

   if (!geom_ok(LEN, WORD) || OFFSET < 0 || OFFSET >= LEN) begin : g_bad_geom
      $error("const_stream_bank: LEN must be a multiple of WORD and OFFSET < LEN");
   end

   bit_idx_t        r_idx;
   logic [N_CH-1:0] w_bit;
   logic            w_acc;

   assign o_ld_ready = ~i_run_en & ~i_sync_clr;
   // A handshake in the reset cycle is void; out-of-range channels match no instance.
   assign w_acc = i_ld_valid & o_ld_ready & ~rst;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      const_pattern_ch #(.LEN(LEN), .WORD(WORD)) u_ch (
         .clk    (clk),
         .i_we   (w_acc && (i_ld_ch == ch_idx_t'(c))),
         .i_addr (i_ld_addr),
         .i_data (i_ld_data),
         .i_idx  (r_idx),
         .o_bit  (w_bit[c])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= IDX_RST;
         o_bits_out   <= '0;
         o_bits_valid <= 1'b0;
         o_wrap       <= 1'b0;
         o_idx_out    <= IDX_RST;
      end else if (i_sync_clr) begin
         r_idx        <= IDX_RST;
         o_bits_out   <= '0;
         o_bits_valid <= 1'b0;
         o_wrap       <= 1'b0;
      end else if (i_run_en) begin
         r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         o_bits_out   <= w_bit & i_ch_mask;
         o_bits_valid <= 1'b1;
         o_wrap       <= (r_idx == IDX_LAST);
         o_idx_out    <= r_idx;
      end else begin
         o_bits_out   <= '0;
         o_bits_valid <= 1'b0;
         o_wrap       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_const_stream_bank.sv
// tb_const_stream_bank: randomized and directed stimulus against a bit-array reference model.
module tb_const_stream_bank;

   localparam int N_CH = 3, LEN = 512, WORD = 32, OFFSET = 5, NW = LEN / WORD;
   localparam int CW = $clog2(N_CH), IW = $clog2(LEN), AW = $clog2(NW);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst = 1'b1, run_en = 1'b0, sync_clr = 1'b0, ld_valid = 1'b0;
   logic [N_CH-1:0] ch_mask = '1;
   logic [CW-1:0]   ld_ch = '0;
   logic [AW-1:0]   ld_addr = '0;
   logic [WORD-1:0] ld_data = '0;
   logic            ld_ready, bits_valid, wrap;
   logic [N_CH-1:0] bits_out;
   logic [IW-1:0]   idx_out;

   const_stream_bank #(.N_CH(N_CH), .LEN(LEN), .WORD(WORD), .OFFSET(OFFSET)) dut (
      .clk(clk), .rst(rst), .i_run_en(run_en), .i_sync_clr(sync_clr), .i_ch_mask(ch_mask),
      .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_ch(ld_ch), .i_ld_addr(ld_addr),
      .i_ld_data(ld_data), .o_bits_out(bits_out), .o_bits_valid(bits_valid), .o_wrap(wrap),
      .o_idx_out(idx_out)
   );

   bit              pat [N_CH][LEN];
   int              m_idx = OFFSET, e_idx = OFFSET;
   logic [N_CH-1:0] e_bits = '0;
   bit              e_valid = 0, e_wrap = 0, e_idx_chk = 0;
   int              n_chk = 0, n_pass = 0;
   bit              wrap_chk = 0;
   int              vcnt = 0, wraps = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Reference: the stream is pattern[c][i] for a cycling index i; loads rewrite bit arrays.
   initial begin
      forever begin
         @(posedge clk);
         e_bits = '0; e_valid = 0; e_wrap = 0; e_idx_chk = 0;
         if (rst) begin
            m_idx = OFFSET; e_idx = OFFSET; e_idx_chk = 1;
         end else if (sync_clr) begin
            m_idx = OFFSET;
         end else if (run_en) begin
            for (int c = 0; c < N_CH; c++) e_bits[c] = pat[c][m_idx] & ch_mask[c];
            e_idx = m_idx; e_valid = 1; e_idx_chk = 1; e_wrap = (m_idx == LEN - 1);
            m_idx = (m_idx + 1) % LEN;
         end
         if (!rst && ld_valid && !run_en && !sync_clr && int'(ld_ch) < N_CH)
            for (int j = 0; j < WORD; j++) pat[ld_ch][int'(ld_addr) * WORD + j] = ld_data[j];
         #1;
         chk("bits_out", bits_out, e_bits);
         chk("bits_valid", bits_valid, e_valid);
         chk("wrap", wrap, e_wrap);
         chk("ld_ready", ld_ready, !run_en && !sync_clr);
         if (e_idx_chk) chk("idx_out", idx_out, e_idx);
         if (wrap_chk && bits_valid) begin
            vcnt++;
            if (wrap) begin
               if (wraps > 0) chk("wrap_period", vcnt, LEN);
               wraps++; vcnt = 0;
            end
         end
      end
   end

   task automatic ld(input int ch, input int addr, input logic [WORD-1:0] d);
      ld_valid = 1'b1; ld_ch = CW'(ch); ld_addr = AW'(addr); ld_data = d;
      @(negedge clk);
      ld_valid = 1'b0;
   endtask

   task automatic wait_idx(input int target);
      for (int i = 0; i < 2 * LEN; i++) begin
         @(posedge clk); #1;
         if (bits_valid && int'(idx_out) == target) return;
      end
      chk("wait_idx_timeout", -1, target);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_bits", bits_out, 0);
      chk("rst_valid", bits_valid, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_idx", idx_out, OFFSET);
      chk("rst_ready", ld_ready, 1);
      rst = 1'b0;
      for (int w = 0; w < NW; w++) begin
         ld(0, w, 32'hAAAA_AAAA);
         ld(1, w, (w == 0) ? 32'h0000_0020 : 32'h0);
         ld(2, w, '1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; run_en = 1'b1; wrap_chk = 1;
      @(posedge clk); #2;
      chk("first_valid", bits_valid, 1);
      chk("first_idx", idx_out, 5);
      chk("first_bits", bits_out, 3'b111);
      @(posedge clk); #2;
      chk("second_idx", idx_out, 6);
      chk("second_bits", bits_out, 3'b100);
      wait_idx(511);
      chk("wrap_bits", bits_out, 3'b101);
      chk("wrap_flag", wrap, 1);
      wait_idx(5);
      chk("period_bits", bits_out, 3'b111);
      wait_idx(511);
      wrap_chk = 0;
      chk("wrap_count", wraps, 2);
      wait_idx(50);
      @(negedge clk);
      ch_mask = 3'b011;
      repeat (3) @(negedge clk);
      ch_mask = '1;
      wait_idx(100);
      @(negedge clk);
      run_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("stopped_ready", ld_ready, 1);
      run_en = 1'b1;
      @(posedge clk); #2;
      chk("resume_idx", idx_out, 101);
      wait_idx(300);
      @(negedge clk);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      @(posedge clk); #2;
      chk("clr_idx", idx_out, OFFSET);
      @(negedge clk);
      ld_valid = 1'b1; ld_ch = 1; ld_addr = 0; ld_data = '1;
      repeat (20) @(negedge clk);
      ld_valid = 1'b0; run_en = 1'b0;
      ld(N_CH, 0, '1);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0; run_en = 1'b1;
      wait_idx(5);
      chk("ch1_intact_5", bits_out, 3'b111);
      wait_idx(6);
      chk("ch1_intact_6", bits_out, 3'b100);
      @(negedge clk);
      ld_valid = 1'b1; ld_ch = 2; ld_addr = 0; ld_data = '0; rst = 1'b1;
      @(posedge clk); #2;
      chk("midrst_valid", bits_valid, 0);
      chk("midrst_idx", idx_out, OFFSET);
      @(negedge clk);
      run_en = 1'b0;
      @(negedge clk);
      rst = 1'b0; ld_valid = 1'b0; run_en = 1'b1;
      wait_idx(7);
      chk("after_rst_bits", bits_out, 3'b101);
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 199) == 0);
         sync_clr = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 31) == 0) run_en = ~run_en;
         if ($urandom_range(0, 7) == 0) ch_mask = N_CH'($urandom);
         ld_valid = $urandom_range(0, 1);
         ld_ch = CW'($urandom_range(0, 3));
         ld_addr = AW'($urandom_range(0, NW - 1));
         ld_data = $urandom;
      end
      @(negedge clk);
      rst = 1'b0; sync_clr = 1'b0; run_en = 1'b0; ld_valid = 1'b0;
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
